// File: rtl/sw_port_arbiter.sv
// Output-port arbiter: picks the highest-priority requesting input (round-robin
// on ties), then streams that input's packet one word per accepted cycle.
module sw_port_arbiter #(
  parameter int NUM_PORTS      = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_PRIORITY = 3,
  parameter int WIDTH_LENGTH   = 9,
  parameter int TIMEOUT        = 255,
  parameter int WIDTH_SEL      = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PORTS-1:0]                 req,
  input  logic [NUM_PORTS*WIDTH_PRIORITY-1:0]  req_priority,
  input  logic [NUM_PORTS*WIDTH_LENGTH-1:0]    req_length,
  input  logic [NUM_PORTS-1:0]                 in_vld,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      in_data,
  input  logic                                 full,
  output logic [NUM_PORTS-1:0]                 grant,
  output logic                                 out_vld,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [WIDTH_SEL-1:0]                 out_src,
  output logic                                 busy,
  output logic                                 pkt_done,
  output logic                                 timeout_err
);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  logic [NUM_PORTS-1:0][WIDTH_PRIORITY-1:0] prio_a;
  logic [NUM_PORTS-1:0][WIDTH_LENGTH-1:0]   len_a;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     data_a;

  assign prio_a = req_priority;
  assign len_a  = req_length;
  assign data_a = in_data;

  logic [0:0]              state_q, state_d;
  logic [WIDTH_SEL-1:0]    owner_q, owner_d;
  logic [WIDTH_SEL-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH_LENGTH-1:0] len_q, len_d;
  logic [WIDTH_LENGTH:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0]       idle_q, idle_d;
  logic                    out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    pkt_done_q, pkt_done_d;
  logic                    timeout_err_q, timeout_err_d;

  // Scan starts just past the last completed owner; strict '>' keeps the
  // first hit in scan order among equal priorities.
  logic                      win_found;
  logic [WIDTH_SEL-1:0]      win_idx;
  logic [WIDTH_PRIORITY-1:0] win_prio;
  logic [WIDTH_SEL-1:0]      scan;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    scan      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      scan = WIDTH_SEL'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (req[scan] && (!win_found || prio_a[scan] > win_prio)) begin
        win_found = 1'b1;
        win_idx   = scan;
        win_prio  = prio_a[scan];
      end
    end
  end

  logic xfer, accept, last, expire;

  assign xfer   = (state_q == S_XFER);
  assign accept = xfer && in_vld[owner_q] && !full;
  assign last   = accept && (cnt_q == {1'b0, len_q});
  assign expire = xfer && !accept && (idle_q == IDLE_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    idle_d        = idle_q;
    out_vld_d     = accept;
    out_data_d    = accept ? data_a[owner_q] : out_data_q;
    pkt_done_d    = 1'b0;
    timeout_err_d = 1'b0;
    if (!xfer) begin
      if (win_found) begin
        state_d = S_XFER;
        owner_d = win_idx;
        len_d   = len_a[win_idx];
        cnt_d   = '0;
        idle_d  = '0;
      end
    end else if (accept) begin
      cnt_d  = cnt_q + 1'b1;
      idle_d = '0;
      if (last) begin
        state_d    = S_IDLE;
        pkt_done_d = 1'b1;
        rr_ptr_d   = owner_q;
      end
    end else if (expire) begin
      // Aborted packets do not advance the round-robin pointer.
      state_d       = S_IDLE;
      timeout_err_d = 1'b1;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      rr_ptr_q      <= WIDTH_SEL'(NUM_PORTS - 1);
      len_q         <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      idle_q        <= idle_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      pkt_done_q    <= pkt_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    grant = '0;
    if (xfer && !full) grant[owner_q] = 1'b1;
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_src     = owner_q;
  assign busy        = xfer;
  assign pkt_done    = pkt_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sw_port_arbiter.sv
// Bench for sw_port_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a packet-level model.
module tb_sw_port_arbiter;
  localparam int NP = 16;
  localparam int DW = 32;
  localparam int WP = 3;
  localparam int WL = 9;
  localparam int TO = 8;
  localparam int WS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NP-1:0]       req = '0;
  logic [NP*WP-1:0]    req_priority = '0;
  logic [NP*WL-1:0]    req_length = '0;
  logic [NP-1:0]       in_vld = '0;
  logic [NP*DW-1:0]    in_data = '0;
  logic                full = 1'b0;
  logic [NP-1:0]       grant;
  logic                out_vld;
  logic [DW-1:0]       out_data;
  logic [WS-1:0]       out_src;
  logic                busy, pkt_done, timeout_err;

  sw_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .WIDTH_PRIORITY(WP),
                    .WIDTH_LENGTH(WL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_priority(req_priority),
    .req_length(req_length), .in_vld(in_vld), .in_data(in_data), .full(full),
    .grant(grant), .out_vld(out_vld), .out_data(out_data), .out_src(out_src),
    .busy(busy), .pkt_done(pkt_done), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Packet-level model: words remaining in the current packet, idle streak.
  bit          m_busy, m_vld, m_pd, m_te;
  int          m_owner, m_left, m_idle, m_rr;
  logic [DW-1:0] m_data;

  function automatic int m_pick();
    int best_p = -1;
    int best_i = -1;
    int best_d = NP + 1;
    for (int i = 0; i < NP; i++)
      if (req[i] && int'(req_priority[i*WP +: WP]) > best_p) best_p = int'(req_priority[i*WP +: WP]);
    for (int i = 0; i < NP; i++) begin
      int d;
      d = (i - m_rr - 1 + 2*NP) % NP;
      if (req[i] && int'(req_priority[i*WP +: WP]) == best_p && d < best_d) begin
        best_d = d;
        best_i = i;
      end
    end
    return best_i;
  endfunction

  task automatic m_reset();
    m_busy = 0; m_vld = 0; m_pd = 0; m_te = 0;
    m_owner = 0; m_left = 0; m_idle = 0; m_rr = NP - 1; m_data = '0;
  endtask

  task automatic m_step();
    m_vld = 0; m_pd = 0; m_te = 0;
    if (rst) m_reset();
    else if (!m_busy) begin
      int w;
      w = m_pick();
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_idle = 0;
        m_left = int'(req_length[w*WL +: WL]) + 1;
      end
    end else if (in_vld[m_owner] && !full) begin
      m_vld = 1; m_data = in_data[m_owner*DW +: DW];
      m_left--; m_idle = 0;
      if (m_left == 0) begin m_busy = 0; m_pd = 1; m_rr = m_owner; end
    end else begin
      m_idle++;
      if (m_idle == TO) begin m_busy = 0; m_te = 1; end
    end
  endtask

  // Compare process: outputs are checked at negedge, then the model takes
  // the inputs that the DUT will sample on the coming posedge.
  initial begin
    logic [NP-1:0] eg;
    @(posedge clk);
    m_reset();
    forever begin
      @(negedge clk);
      eg = '0;
      if (m_busy && !full) eg[m_owner] = 1'b1;
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("out_vld", 64'(out_vld), 64'(m_vld));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_src", 64'(out_src), 64'(m_owner));
      chk("pkt_done", 64'(pkt_done), 64'(m_pd));
      chk("timeout_err", 64'(timeout_err), 64'(m_te));
      m_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic mid(); @(negedge clk); #1; endtask
  task automatic adv(); @(posedge clk); #1; endtask

  task automatic set_port(input int i, input int p, input int l);
    req_priority[i*WP +: WP] = WP'(p);
    req_length[i*WL +: WL]   = WL'(l);
  endtask

  task automatic rnd_data();
    for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = $urandom;
  endtask

  task automatic quiet(input int n);
    req = '0; in_vld = '0; full = 1'b0;
    repeat (n) adv();
  endtask

  logic [NP-1:0] g_h [32];
  logic [WS-1:0] s_h [32];
  logic          v_h [32], pd_h [32], te_h [32], b_h [32];

  // Records a window of cycles; drops req/in_vld of ports once granted.
  task automatic observe(input int n, input logic [NP-1:0] dreq,
                         input logic [NP-1:0] dvld, input logic [31:0] fs);
    for (int k = 0; k < n; k++) begin
      full = fs[k];
      mid();
      g_h[k] = grant; v_h[k] = out_vld; s_h[k] = out_src;
      pd_h[k] = pkt_done; te_h[k] = timeout_err; b_h[k] = busy;
      adv();
      rnd_data();
      req    = req & ~(g_h[k] & dreq);
      in_vld = in_vld & ~(g_h[k] & dvld);
    end
    full = 1'b0;
  endtask

  function automatic int cnt_grant(input int n, input logic [NP-1:0] g);
    int c = 0;
    for (int k = 0; k < n; k++) if (g_h[k] == g) c++;
    return c;
  endfunction

  function automatic int cnt_bits(input int n, input int sel);
    int c = 0;
    for (int k = 0; k < n; k++)
      case (sel)
        0: c += int'(v_h[k]);
        1: c += int'(pd_h[k]);
        2: c += int'(te_h[k]);
        default: c += int'(b_h[k] && g_h[k] == '0);
      endcase
    return c;
  endfunction

  initial begin
    logic [NP-1:0] seq [4];
    int ns, pct;
    rnd_data();
    repeat (3) adv();
    mid();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_out_vld", 64'(out_vld), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_src", 64'(out_src), 64'h0);
    adv();
    rst = 1'b0;
    quiet(2);

    // Single request: port 3, length 4 -> five words.
    set_port(3, 2, 4); req = 16'h0008; in_vld = 16'h0008;
    observe(9, '1, '0, 32'h0);
    chk("s1_grant_cycles", 64'(cnt_grant(9, 16'h0008)), 64'd5);
    chk("s1_first_grant", 64'(g_h[1]), 64'h0008);
    chk("s1_beats", 64'(cnt_bits(9, 0)), 64'd5);
    chk("s1_src", 64'(s_h[2]), 64'd3);
    chk("s1_pkt_done_at", 64'(pd_h[6]), 64'd1);
    chk("s1_pkt_done_cnt", 64'(cnt_bits(9, 1)), 64'd1);
    chk("s1_grant_after", 64'(g_h[7]), 64'h0);
    quiet(2);

    // Priority contention: 7 (prio 5) beats 1 (prio 1); 1 follows after one idle cycle.
    set_port(1, 1, 0); set_port(7, 5, 0);
    req = 16'h0082; in_vld = 16'h0082;
    observe(6, '1, '0, 32'h0);
    chk("s2_first", 64'(g_h[1]), 64'h0080);
    chk("s2_gap", 64'(g_h[2]), 64'h0);
    chk("s2_pkt_done", 64'(pd_h[2]), 64'd1);
    chk("s2_second", 64'(g_h[3]), 64'h0002);
    quiet(1);
    rst = 1'b1; adv(); rst = 1'b0; quiet(1);

    // Round-robin tie on 0, 2, 5 with requests held.
    set_port(0, 4, 0); set_port(2, 4, 0); set_port(5, 4, 0);
    req = 16'h0025; in_vld = 16'h0025;
    observe(8, '0, '0, 32'h0);
    ns = 0;
    for (int k = 0; k < 8; k++)
      if (g_h[k] != '0 && ns < 4) begin seq[ns] = g_h[k]; ns++; end
    chk("s3_count", 64'(ns), 64'd4);
    chk("s3_g0", 64'(seq[0]), 64'h0001);
    chk("s3_g1", 64'(seq[1]), 64'h0004);
    chk("s3_g2", 64'(seq[2]), 64'h0020);
    chk("s3_g3", 64'(seq[3]), 64'h0001);
    quiet(3);

    // Backpressure: full for 3 cycles after the control word, length 2.
    set_port(6, 3, 2); req = 16'h0040; in_vld = 16'h0040;
    observe(10, '1, '0, 32'h0000_001C);
    chk("s4_stall_zero_grant", 64'(cnt_bits(10, 3)), 64'd3);
    chk("s4_grant_cycles", 64'(cnt_grant(10, 16'h0040)), 64'd3);
    chk("s4_beats", 64'(cnt_bits(10, 0)), 64'd3);
    chk("s4_no_timeout", 64'(cnt_bits(10, 2)), 64'd0);
    chk("s4_pkt_done", 64'(cnt_bits(10, 1)), 64'd1);
    quiet(1);
    rst = 1'b1; adv(); rst = 1'b0; quiet(1);

    // Timeout: owner stops after the control word.
    set_port(4, 2, 3); req = 16'h0010; in_vld = 16'h0010;
    observe(13, '1, 16'h0010, 32'h0);
    chk("s5_beats", 64'(cnt_bits(13, 0)), 64'd1);
    chk("s5_busy_last", 64'(b_h[9]), 64'd1);
    chk("s5_timeout_at", 64'(te_h[10]), 64'd1);
    chk("s5_timeout_cnt", 64'(cnt_bits(13, 2)), 64'd1);
    chk("s5_no_pkt_done", 64'(cnt_bits(13, 1)), 64'd0);
    quiet(1);
    // rr_ptr still at 15 -> port 2 wins over 6 (would be 6 if it had moved to 4).
    set_port(2, 1, 0); set_port(6, 1, 0);
    req = 16'h0044; in_vld = 16'h0044;
    observe(4, '1, '0, 32'h0);
    chk("s5_rr_first", 64'(g_h[1]), 64'h0004);
    chk("s5_rr_second", 64'(g_h[3]), 64'h0040);
    quiet(3);

    // Reset while the fourth word of a length-9 packet is accepted.
    set_port(9, 3, 9); req = 16'h0200; in_vld = 16'h0200;
    observe(4, '1, '0, 32'h0);
    rst = 1'b1;
    adv();
    rst = 1'b0; req = '0;
    mid();
    chk("s6_grant", 64'(grant), 64'h0);
    chk("s6_out_vld", 64'(out_vld), 64'h0);
    chk("s6_busy", 64'(busy), 64'h0);
    chk("s6_pkt_done", 64'(pkt_done), 64'h0);
    chk("s6_timeout", 64'(timeout_err), 64'h0);
    adv();
    set_port(0, 5, 0); set_port(9, 5, 0);
    req = 16'h0201; in_vld = 16'h0201;
    observe(2, '1, '0, 32'h0);
    chk("s6_tie_after_reset", 64'(g_h[1]), 64'h0001);
    quiet(2);

    // Random traffic; in_vld density varies per segment to hit timeouts.
    pct = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) pct = ($urandom_range(0, 2) == 0) ? 10 : ($urandom_range(0, 1) ? 60 : 95);
      rst  = ($urandom_range(0, 599) == 0);
      req  = NP'($urandom & $urandom & $urandom);
      for (int i = 0; i < NP; i++) begin
        set_port(i, $urandom_range(0, 2), $urandom_range(0, 5));
        in_vld[i] = ($urandom_range(0, 99) < pct);
      end
      rnd_data();
      full = ($urandom_range(0, 99) < 15);
      adv();
    end
    rst = 1'b0;
    quiet(2);
    mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
